n64adv_vclk_sel_ctrl: RTL and testbench

Video-clock selection controller sitting directly upstream of the clock/reset housekeeping block. It turns the controller's line-multiplier setting into the `VCLK_select` code that drives the video clock mux. Every change goes through a sequence: debounce the setting, blank the video, check that the 75 MHz PLL is locked, switch, then blank again. If the PLL fails to lock, or loses lock, the block falls back to the direct VCLK path.

---
 rtl/n64adv_vclk_sel_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_n64adv_vclk_sel_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/n64adv_vclk_sel_ctrl.sv
// Video-clock select sequencer: debounces the line-multiplier setting, blanks video around
// every VCLK mux change, qualifies PLL lock before selecting it and falls back to direct VCLK.
module n64adv_vclk_sel_ctrl #(
    parameter int CFG_STABLE_CYC   = 16,
    parameter int BLANK_CYC        = 64,
    parameter int LOCK_STABLE_CYC  = 256,
    parameter int LOCK_TIMEOUT_CYC = 4096
) (
    input  logic       VCLK,
    input  logic       nVRST,
    input  logic [1:0] cfg_linemult,
    input  logic       VCLK_PLL_LOCKED,
    output logic [1:0] VCLK_select,
    output logic       blank_req,
    output logic       sel_busy,
    output logic       pll_fallback
);

    localparam int CFG_W   = $clog2(CFG_STABLE_CYC);
    localparam int BLANK_W = $clog2(BLANK_CYC);
    localparam int LOCK_W  = $clog2(LOCK_STABLE_CYC);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT_CYC);

    localparam logic [CFG_W-1:0]   CFG_ONE    = CFG_W'(1);
    localparam logic [CFG_W-1:0]   CFG_LAST   = CFG_W'(CFG_STABLE_CYC - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [3:0]         LOSS_LAST  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK_PRE,
        S_WAIT_LOCK,
        S_SWITCH,
        S_BLANK_POST
    } state_t;

    state_t state_reg;

    logic [2:0] async_in;
    logic [2:0] sync_bus;
    logic [1:0] cfg_sync;
    logic       lock_sync;

    logic [1:0]         cfg_prev_reg;
    logic [CFG_W-1:0]   cfg_cnt_reg;
    logic [1:0]         cfg_acc_reg;
    logic [1:0]         tgt;
    logic               start_req;

    logic [1:0]         tgt_q_reg;
    logic [1:0]         fb_tgt_reg;
    logic [BLANK_W-1:0] blank_cnt_reg;
    logic [LOCK_W-1:0]  lock_cnt_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [3:0]         loss_cnt_reg;

    assign async_in = {VCLK_PLL_LOCKED, cfg_linemult};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge VCLK or negedge nVRST) begin
                if (!nVRST) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bus[gi] = sync_reg;
        end
    endgenerate

    assign cfg_sync  = sync_bus[1:0];
    assign lock_sync = sync_bus[2];

    // cfg_cnt_reg holds how many cycles the synced value has been unchanged (saturating)
    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            cfg_prev_reg <= 2'b00;
            cfg_cnt_reg  <= '0;
            cfg_acc_reg  <= 2'b00;
        end else begin
            cfg_prev_reg <= cfg_sync;
            if (cfg_sync != cfg_prev_reg) begin
                cfg_cnt_reg <= CFG_ONE;
            end else if (cfg_cnt_reg != CFG_LAST) begin
                cfg_cnt_reg <= cfg_cnt_reg + 1'b1;
            end else begin
                cfg_acc_reg <= cfg_sync;
            end
        end
    end

    always_comb begin
        tgt = 2'b00;
        case (cfg_acc_reg)
            2'b01:   tgt = 2'b10;
            2'b10:   tgt = 2'b11;
            default: tgt = 2'b00;
        endcase
    end

    // After a fallback only a setting different from the one that failed may start a sequence
    assign start_req = pll_fallback ? (tgt != fb_tgt_reg) : (tgt != VCLK_select);

    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            state_reg     <= S_IDLE;
            VCLK_select   <= 2'b00;
            blank_req     <= 1'b0;
            sel_busy      <= 1'b0;
            pll_fallback  <= 1'b0;
            tgt_q_reg     <= 2'b00;
            fb_tgt_reg    <= 2'b00;
            blank_cnt_reg <= '0;
            lock_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            loss_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (VCLK_select[1] && !lock_sync) begin
                        loss_cnt_reg <= loss_cnt_reg + 1'b1;
                    end else begin
                        loss_cnt_reg <= '0;
                    end
                    if (VCLK_select[1] && !lock_sync && loss_cnt_reg == LOSS_LAST) begin
                        tgt_q_reg     <= 2'b00;
                        fb_tgt_reg    <= VCLK_select;
                        pll_fallback  <= 1'b1;
                        loss_cnt_reg  <= '0;
                        blank_cnt_reg <= '0;
                        blank_req     <= 1'b1;
                        sel_busy      <= 1'b1;
                        state_reg     <= S_BLANK_PRE;
                    end else if (start_req) begin
                        tgt_q_reg <= tgt;
                        if (pll_fallback) begin
                            fb_tgt_reg <= tgt;
                        end
                        blank_cnt_reg <= '0;
                        blank_req     <= 1'b1;
                        sel_busy      <= 1'b1;
                        state_reg     <= S_BLANK_PRE;
                    end
                end
                S_BLANK_PRE: begin
                    if (blank_cnt_reg == BLANK_LAST) begin
                        blank_cnt_reg <= '0;
                        lock_cnt_reg  <= '0;
                        to_cnt_reg    <= '0;
                        state_reg     <= tgt_q_reg[1] ? S_WAIT_LOCK : S_SWITCH;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    // a lock glitch restarts only the stability count, never the timeout
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                    if (lock_sync) begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end else begin
                        lock_cnt_reg <= '0;
                    end
                    if (lock_sync && lock_cnt_reg == LOCK_LAST) begin
                        state_reg <= S_SWITCH;
                    end else if (to_cnt_reg == TO_LAST) begin
                        fb_tgt_reg   <= tgt_q_reg;
                        tgt_q_reg    <= 2'b00;
                        pll_fallback <= 1'b1;
                        state_reg    <= S_SWITCH;
                    end
                end
                S_SWITCH: begin
                    VCLK_select <= tgt_q_reg;
                    if (tgt_q_reg[1]) begin
                        pll_fallback <= 1'b0;
                    end
                    blank_cnt_reg <= '0;
                    state_reg     <= S_BLANK_POST;
                end
                S_BLANK_POST: begin
                    if (blank_cnt_reg == BLANK_LAST) begin
                        blank_cnt_reg <= '0;
                        loss_cnt_reg  <= '0;
                        blank_req     <= 1'b0;
                        sel_busy      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end else begin
                        blank_cnt_reg <= blank_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    blank_req <= 1'b0;
                    sel_busy  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64adv_vclk_sel_ctrl.sv
// Bench for n64adv_vclk_sel_ctrl: expected output changes {select,blank,busy,fallback} with
// their cycle stamps are queued by the stimulus and matched by an independent monitor.
module tb_n64adv_vclk_sel_ctrl;

    logic       VCLK = 1'b0;
    logic       nVRST = 1'b1;
    logic [1:0] cfg_linemult = 2'b00;
    logic       VCLK_PLL_LOCKED = 1'b1;
    logic [1:0] VCLK_select;
    logic       blank_req;
    logic       sel_busy;
    logic       pll_fallback;

    n64adv_vclk_sel_ctrl dut (
        .VCLK            (VCLK),
        .nVRST           (nVRST),
        .cfg_linemult    (cfg_linemult),
        .VCLK_PLL_LOCKED (VCLK_PLL_LOCKED),
        .VCLK_select     (VCLK_select),
        .blank_req       (blank_req),
        .sel_busy        (sel_busy),
        .pll_fallback    (pll_fallback)
    );

    always #5 VCLK = ~VCLK;

    typedef struct {
        logic [4:0] outs;
        int         at;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [4:0] prev_outs = 5'b00000;

    always @(posedge VCLK) cyc <= cyc + 1;

    // Monitor: every change of the output tuple is one transaction
    always @(negedge VCLK) begin : monitor
        logic [4:0] cur;
        exp_t       e;
        cur = {VCLK_select, blank_req, sel_busy, pll_fallback};
        if (cur != prev_outs) begin
            if (cur[4:3] != prev_outs[4:3] && nVRST) begin
                n_checks++;
                if (!blank_req) begin
                    n_fail++;
                    $display("FAIL sel_while_unblanked: cyc=%0d select %b changed with blank_req=0, required blank_req=1",
                             cyc, cur[4:3]);
                end
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc=%0d outs=%b, required no change from %b", cyc, cur, prev_outs);
            end else begin
                e = exp_q.pop_front();
                if (cur != e.outs || (e.at >= 0 && cyc != e.at)) begin
                    n_fail++;
                    $display("FAIL out_event: got outs=%b at cyc %0d, required outs=%b at cyc %0d",
                             cur, cyc, e.outs, e.at);
                end else begin
                    $display("event ok: cyc=%0d outs(sel,blank,busy,fb)=%b", cyc, cur);
                end
            end
            prev_outs = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge VCLK);
        #1;
    endtask

    task automatic expect_ev(input logic [4:0] o, input int a);
        exp_t e;
        e.outs = o;
        e.at   = a;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end else begin
            $display("check ok: %s = %b", name, got);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge VCLK);
            k++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end else begin
            $display("drain ok: %s at cyc %0d", name, cyc);
        end
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, applies new inputs, releases.
    task automatic reset_pulse(input logic [1:0] cfg, input logic lock, input logic outs_change, output int t_rel);
        if (outs_change) expect_ev(5'b00000, -1);
        nVRST = 1'b0;
        #1;
        check("async_reset_outs", {VCLK_select, blank_req, sel_busy, pll_fallback}, 5'b00000);
        cfg_linemult    = cfg;
        VCLK_PLL_LOCKED = lock;
        tick(4);
        nVRST = 1'b1;
        t_rel = cyc;
    endtask

    initial begin : stim
        int t0;
        int t1;
        int t2;

        // Power-on reset
        #2 nVRST = 1'b0;
        #1 check("por_outs", {VCLK_select, blank_req, sel_busy, pll_fallback}, 5'b00000);
        tick(5);
        nVRST = 1'b1;
        tick(30);

        // LineX2 with PLL locked: 2+16+1+64+256+1 = 340 cycles to select 10
        t0 = cyc;
        cfg_linemult = 2'b01;
        expect_ev(5'b00110, t0 + 19);
        expect_ev(5'b10110, t0 + 340);
        expect_ev(5'b10000, t0 + 404);
        wait_drain(500, "x2_locked");
        check("x2_fallback", {4'b0000, pll_fallback}, 5'b00000);

        // LineX3 with PLL never locking: timeout, fallback, no retry
        reset_pulse(2'b10, 1'b0, 1'b1, t0);
        expect_ev(5'b00110, t0 + 19);
        expect_ev(5'b00111, t0 + 4179);
        expect_ev(5'b00001, t0 + 4244);
        wait_drain(4400, "x3_timeout");
        tick(300);
        check("no_retry_state", {VCLK_select, 1'b0, sel_busy, pll_fallback}, 5'b00001);

        // Setting bouncing every 8 cycles never gets accepted
        for (int i = 0; i < 12; i++) begin
            cfg_linemult = i[0] ? 2'b01 : 2'b00;
            tick(8);
            check("toggle_busy", {4'b0000, sel_busy}, 5'b00000);
        end
        cfg_linemult = 2'b10;
        tick(60);
        check("toggle_end_state", {VCLK_select, blank_req, sel_busy, pll_fallback}, 5'b00001);

        // Reach 11, then lose lock for 16 cycles
        reset_pulse(2'b10, 1'b1, 1'b1, t0);
        expect_ev(5'b00110, t0 + 19);
        expect_ev(5'b11110, t0 + 340);
        expect_ev(5'b11000, t0 + 404);
        wait_drain(500, "x3_locked");
        tick(10);
        t1 = cyc;
        VCLK_PLL_LOCKED = 1'b0;
        expect_ev(5'b11111, t1 + 18);
        expect_ev(5'b00111, t1 + 83);
        expect_ev(5'b00001, t1 + 147);
        wait_drain(200, "lock_loss");
        VCLK_PLL_LOCKED = 1'b1;
        tick(20);
        t2 = cyc;
        cfg_linemult = 2'b01;
        expect_ev(5'b00111, t2 + 19);
        expect_ev(5'b10110, t2 + 340);
        expect_ev(5'b10000, t2 + 404);
        wait_drain(500, "recover_x2");

        // Setting changed during BLANK_PRE: first sequence completes, second follows
        reset_pulse(2'b00, 1'b1, 1'b1, t0);
        tick(30);
        t0 = cyc;
        cfg_linemult = 2'b01;
        expect_ev(5'b00110, t0 + 19);
        expect_ev(5'b10110, t0 + 340);
        expect_ev(5'b10000, t0 + 404);
        expect_ev(5'b10110, t0 + 405);
        expect_ev(5'b00110, t0 + 470);
        expect_ev(5'b00000, t0 + 534);
        tick(40);
        cfg_linemult = 2'b00;
        wait_drain(700, "change_in_blank");

        // Reset asserted during WAIT_LOCK, then sequence restarts from debounce
        reset_pulse(2'b10, 1'b0, 1'b0, t0);
        expect_ev(5'b00110, t0 + 19);
        wait_drain(100, "wait_lock_entry");
        tick(150);
        reset_pulse(2'b10, 1'b1, 1'b1, t1);
        expect_ev(5'b00110, t1 + 19);
        expect_ev(5'b11110, t1 + 340);
        expect_ev(5'b11000, t1 + 404);
        wait_drain(500, "restart_after_reset");
        check("final_fallback", {4'b0000, pll_fallback}, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required stimulus to complete");
        $fatal(1, "watchdog expired");
    end

endmodule
